// File: rtl/mbc_pkg.sv
// Shared constants, types and size-code helpers for the MBC3/MBC30 mapper and its RTC.
package mbc_pkg;

  localparam logic [3:0] RTC_SEL_S  = 4'h8;
  localparam logic [3:0] RTC_SEL_M  = 4'h9;
  localparam logic [3:0] RTC_SEL_H  = 4'ha;
  localparam logic [3:0] RTC_SEL_DL = 4'hb;
  localparam logic [3:0] RTC_SEL_DH = 4'hc;

  localparam int DH_D8_BIT    = 0;
  localparam int DH_HALT_BIT  = 6;
  localparam int DH_CARRY_BIT = 7;

  typedef enum logic [2:0] {
    REG_S  = 3'd0,
    REG_M  = 3'd1,
    REG_H  = 3'd2,
    REG_DL = 3'd3,
    REG_DH = 3'd4
  } rtc_reg_e;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [8:0] day;
    logic       halt;
    logic       carry;
  } rtc_time_t;

  // Header code n selects 32kB << n; codes beyond 4MB clamp to the full 22-bit space.
  function automatic logic [21:0] rom_mask(input logic [3:0] size_code);
    if (size_code >= 4'd7) return 22'h3fffff;
    return (22'h008000 << size_code) - 22'd1;
  endfunction

  function automatic logic [21:0] ram_mask(input logic [2:0] size_code);
    case (size_code)
      3'd0:    return 22'h000000;
      3'd1:    return 22'h0007ff;
      3'd2:    return 22'h001fff;
      3'd3:    return 22'h007fff;
      3'd4:    return 22'h01ffff;
      3'd5:    return 22'h00ffff;
      default: return 22'h00ffff;
    endcase
  endfunction

  // Seconds/minutes step: 59 wraps with carry, 63 wraps silently, anything else counts up.
  function automatic logic [6:0] step60(input logic [5:0] v);
    if (v == 6'd59) return {1'b1, 6'd0};
    if (v == 6'd63) return {1'b0, 6'd0};
    return {1'b0, v + 6'd1};
  endfunction

endpackage

// File: rtl/mbc_rtc.sv
// RTC core: prescaler, S/M/H/D counter chain with halt and sticky day carry, latch copy, indexed access.
module mbc_rtc
  import mbc_pkg::*;
#(
  parameter int TICK_DIV = 4194304
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  rtc_reg_e   wr_idx,
  input  logic [7:0] wr_data,
  input  logic       latch_en,
  input  rtc_reg_e   rd_idx,
  output logic [7:0] rd_data
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_reg;
  rtc_time_t     live_reg;
  rtc_time_t     latched_reg;
  rtc_time_t     adv_next;
  logic          terminal;
  logic [6:0]    s_step;
  logic [6:0]    m_step;
  logic          unused_dh_bits;

  assign terminal       = (presc_reg == TERM);
  assign unused_dh_bits = ^wr_data[5:1];

  always_comb begin
    adv_next = live_reg;
    s_step   = step60(live_reg.sec);
    m_step   = step60(live_reg.min);
    adv_next.sec = s_step[5:0];
    if (s_step[6]) begin
      adv_next.min = m_step[5:0];
      if (m_step[6]) begin
        if (live_reg.hour == 5'd23) begin
          adv_next.hour = 5'd0;
          if (live_reg.day == 9'd511) begin
            adv_next.day   = 9'd0;
            adv_next.carry = 1'b1;
          end else begin
            adv_next.day = live_reg.day + 9'd1;
          end
        end else if (live_reg.hour == 5'd31) begin
          adv_next.hour = 5'd0;
        end else begin
          adv_next.hour = live_reg.hour + 5'd1;
        end
      end
    end
  end

  // A write in the terminal cycle wins; the prescaler parks at terminal so the tick lands next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      live_reg  <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        REG_S: begin
          live_reg.sec <= wr_data[5:0];
          presc_reg    <= '0;
        end
        REG_M:  live_reg.min      <= wr_data[5:0];
        REG_H:  live_reg.hour     <= wr_data[4:0];
        REG_DL: live_reg.day[7:0] <= wr_data;
        REG_DH: begin
          live_reg.day[8] <= wr_data[DH_D8_BIT];
          live_reg.halt   <= wr_data[DH_HALT_BIT];
          live_reg.carry  <= wr_data[DH_CARRY_BIT];
        end
        default: ;
      endcase
    end else if (!live_reg.halt) begin
      if (terminal) begin
        presc_reg <= '0;
        live_reg  <= adv_next;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latched_reg <= '0;
    end else if (latch_en) begin
      latched_reg <= live_reg;
    end
  end

  always_comb begin
    rd_data = 8'hff;
    case (rd_idx)
      REG_S:   rd_data = {2'b00, latched_reg.sec};
      REG_M:   rd_data = {2'b00, latched_reg.min};
      REG_H:   rd_data = {3'b000, latched_reg.hour};
      REG_DL:  rd_data = latched_reg.day[7:0];
      REG_DH:  rd_data = {latched_reg.carry, latched_reg.halt, 5'b00000, latched_reg.day[8]};
      default: rd_data = 8'hff;
    endcase
  end

endmodule

// File: rtl/mbc3_rtc.sv
// MBC3/MBC30 mapper top: write-commit detect, control registers, ROM/SRAM address map, RTC access.
module mbc3_rtc
  import mbc_pkg::*;
#(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2,
  parameter int HAS_RTC       = 1,
  parameter int TICK_DIV      = 4194304
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] iadr,
  input  logic [7:0]  data,
  input  logic        write,
  input  logic        ics_rom,
  input  logic        ics_ram,
  output logic [21:0] oadr,
  output logic        ocs_rom,
  output logic        ocs_ram,
  output logic        rtc_sel,
  output logic [7:0]  rtc_dout,
  input  logic [3:0]  rom_size,
  input  logic [2:0]  ram_size
);

  logic                     pwrite_reg;
  logic [ROM_BANK_BITS-1:0] rom_bank_reg;
  logic [3:0]               ram_sel_reg;
  logic                     ena_ram_reg;
  logic                     latch_arm_reg;

  logic       commit;
  logic       rom_commit;
  logic       latch_en;
  logic       rtc_hit;
  logic       ram_in_range;
  logic       rtc_wr;
  rtc_reg_e   rtc_idx;
  logic [7:0] rtc_rd;
  logic [7:0] bank_ext;
  logic [7:0] eff_bank;

  logic [21:0] oadr_c;
  logic        ocs_rom_c;
  logic        ocs_ram_c;
  logic        rtc_sel_c;
  logic [7:0]  rtc_dout_c;

  // Writes take effect on the clock edge that first sees the strobe low after it was high.
  assign commit     = pwrite_reg & ~write & (ics_rom | ics_ram);
  assign rom_commit = commit & ics_rom;
  assign latch_en   = rom_commit & (iadr[14:13] == 2'b11) & latch_arm_reg & (data == 8'h01);

  assign rtc_hit      = (HAS_RTC != 0) && (ram_sel_reg >= RTC_SEL_S) && (ram_sel_reg <= RTC_SEL_DH);
  assign ram_in_range = (int'(ram_sel_reg) < (1 << RAM_BANK_BITS));
  assign rtc_wr       = commit & ~ics_rom & ics_ram & ena_ram_reg & rtc_hit;
  assign rtc_idx      = rtc_reg_e'(3'(ram_sel_reg - RTC_SEL_S));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwrite_reg    <= 1'b0;
      rom_bank_reg  <= '0;
      ram_sel_reg   <= 4'h0;
      ena_ram_reg   <= 1'b0;
      latch_arm_reg <= 1'b0;
    end else begin
      pwrite_reg <= write;
      if (rom_commit) begin
        case (iadr[14:13])
          2'b00:   ena_ram_reg   <= (data[3:0] == 4'ha);
          2'b01:   rom_bank_reg  <= data[ROM_BANK_BITS-1:0];
          2'b10:   ram_sel_reg   <= data[3:0];
          default: latch_arm_reg <= (data == 8'h00);
        endcase
      end
    end
  end

  generate
    if (HAS_RTC != 0) begin : g_rtc
      mbc_rtc #(
        .TICK_DIV (TICK_DIV)
      ) u_rtc (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (rtc_wr),
        .wr_idx   (rtc_idx),
        .wr_data  (data),
        .latch_en (latch_en),
        .rd_idx   (rtc_idx),
        .rd_data  (rtc_rd)
      );
    end else begin : g_no_rtc
      assign rtc_rd = 8'hff;
    end
  endgenerate

  // Bank 0 aliases to 1 only on an exact zero, so 0x20/0x40/0x60 remain reachable.
  assign bank_ext = 8'(rom_bank_reg);
  assign eff_bank = (rom_bank_reg == '0) ? 8'd1 : bank_ext;

  always_comb begin
    oadr_c     = {7'b0, iadr};
    ocs_rom_c  = 1'b0;
    ocs_ram_c  = 1'b0;
    rtc_sel_c  = 1'b0;
    rtc_dout_c = 8'hff;
    if (ics_rom) begin
      ocs_rom_c = 1'b1;
      if (iadr[14]) oadr_c = {eff_bank, iadr[13:0]} & rom_mask(rom_size);
      else          oadr_c = {8'b0, iadr[13:0]} & rom_mask(rom_size);
    end else if (ics_ram) begin
      if (!ena_ram_reg) begin
        rtc_sel_c = 1'b1;
      end else if (ram_in_range) begin
        ocs_ram_c = |ram_size;
        oadr_c    = 22'({ram_sel_reg, iadr[12:0]}) & ram_mask(ram_size);
      end else if (rtc_hit) begin
        rtc_sel_c  = 1'b1;
        rtc_dout_c = rtc_rd;
      end else begin
        rtc_sel_c = 1'b1;
      end
    end
  end

  // Chip selects and the RTC read path are forced idle for as long as reset is asserted.
  assign oadr     = oadr_c;
  assign ocs_rom  = ocs_rom_c & reset_n;
  assign ocs_ram  = ocs_ram_c & reset_n;
  assign rtc_sel  = rtc_sel_c & reset_n;
  assign rtc_dout = reset_n ? rtc_dout_c : 8'hff;

endmodule

// File: tb/tb_mbc3_rtc.sv
// Directed bench for mbc3_rtc in MBC30 configuration with a fast RTC prescaler.
module tb_mbc3_rtc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] iadr;
  logic [7:0]  data;
  logic        write;
  logic        ics_rom;
  logic        ics_ram;
  logic [21:0] oadr;
  logic        ocs_rom;
  logic        ocs_ram;
  logic        rtc_sel;
  logic [7:0]  rtc_dout;
  logic [3:0]  rom_size;
  logic [2:0]  ram_size;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mbc3_rtc #(
    .ROM_BANK_BITS (8),
    .RAM_BANK_BITS (3),
    .HAS_RTC       (1),
    .TICK_DIV      (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .iadr     (iadr),
    .data     (data),
    .write    (write),
    .ics_rom  (ics_rom),
    .ics_ram  (ics_ram),
    .oadr     (oadr),
    .ocs_rom  (ocs_rom),
    .ocs_ram  (ocs_ram),
    .rtc_sel  (rtc_sel),
    .rtc_dout (rtc_dout),
    .rom_size (rom_size),
    .ram_size (ram_size)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("chk %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Strobe high for one edge, low for the next; the commit lands on the second edge.
  task automatic do_write(input logic to_rom, input logic [14:0] a, input logic [7:0] d);
    ics_rom = to_rom;
    ics_ram = ~to_rom;
    iadr    = a;
    data    = d;
    write   = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
    @(posedge clk);
    #1;
    ics_rom = 1'b0;
    ics_ram = 1'b0;
  endtask

  task automatic rtc_wr(input logic [3:0] sel, input logic [7:0] v);
    do_write(1'b1, 15'h4000, {4'h0, sel});
    do_write(1'b0, 15'h2000, v);
  endtask

  task automatic chk_rtc(input string tag, input logic [3:0] sel, input logic [7:0] exp);
    do_write(1'b1, 15'h4000, {4'h0, sel});
    ics_ram = 1'b1;
    iadr    = 15'h2000;
    #1;
    chk(tag, {24'h0, rtc_dout}, {24'h0, exp});
    ics_ram = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    iadr     = 15'h0;
    data     = 8'h0;
    write    = 1'b0;
    ics_rom  = 1'b0;
    ics_ram  = 1'b0;
    rom_size = 4'd7;
    ram_size = 3'd5;

    // Reset state
    #2 ics_rom = 1'b1;
    #1 chk("rst_ocs_rom", {31'h0, ocs_rom}, 32'h0);
    ics_rom = 1'b0;
    ics_ram = 1'b1;
    #1;
    chk("rst_ocs_ram", {31'h0, ocs_ram}, 32'h0);
    chk("rst_rtc_sel", {31'h0, rtc_sel}, 32'h0);
    chk("rst_rtc_dout", {24'h0, rtc_dout}, 32'hff);
    ics_ram = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ROM mapping
    do_write(1'b1, 15'h2000, 8'h00);
    ics_rom = 1'b1; iadr = 15'h4000;
    #1 chk("rom_bank0_as_1", {10'h0, oadr}, 32'h004000);
    chk("rom_ocs", {31'h0, ocs_rom}, 32'h1);
    ics_rom = 1'b0;
    do_write(1'b1, 15'h2000, 8'h20);
    ics_rom = 1'b1; iadr = 15'h4000;
    #1 chk("rom_bank20", {10'h0, oadr}, 32'h080000);
    ics_rom = 1'b0;
    do_write(1'b1, 15'h2000, 8'hff);
    ics_rom = 1'b1; iadr = 15'h7fff;
    #1 chk("rom_bankff_4mb", {10'h0, oadr}, 32'h3fffff);
    rom_size = 4'd5;
    #1 chk("rom_bankff_1mb", {10'h0, oadr}, 32'h0fffff);
    rom_size = 4'd7; iadr = 15'h1234;
    #1 chk("rom_low_fixed", {10'h0, oadr}, 32'h001234);
    ics_rom = 1'b0; iadr = 15'h5555;
    #1 chk("passthrough", {10'h0, oadr}, 32'h005555);
    chk("passthrough_ocs", {31'h0, ocs_rom}, 32'h0);

    // SRAM mapping and RTC select decode
    do_write(1'b1, 15'h0000, 8'h0a);
    do_write(1'b1, 15'h4000, 8'h03);
    ics_ram = 1'b1; iadr = 15'h2abc;
    #1 chk("ram_bank3_adr", {10'h0, oadr}, 32'h006abc);
    chk("ram_bank3_ocs", {31'h0, ocs_ram}, 32'h1);
    chk("ram_bank3_rtcsel", {31'h0, rtc_sel}, 32'h0);
    ics_ram = 1'b0;
    do_write(1'b1, 15'h4000, 8'h07);
    ram_size = 3'd3; ics_ram = 1'b1; iadr = 15'h3fff;
    #1 chk("ram_bank7_32k", {10'h0, oadr}, 32'h007fff);
    ram_size = 3'd0;
    #1 chk("ram_none_ocs", {31'h0, ocs_ram}, 32'h0);
    ram_size = 3'd5; ics_ram = 1'b0;
    do_write(1'b1, 15'h4000, 8'h0d);
    ics_ram = 1'b1;
    #1 chk("sel0d_dout", {24'h0, rtc_dout}, 32'hff);
    chk("sel0d_rtcsel", {31'h0, rtc_sel}, 32'h1);
    chk("sel0d_ocs", {31'h0, ocs_ram}, 32'h0);
    ics_ram = 1'b0;
    chk_rtc("latched_s_after_reset", 4'h8, 8'h00);
    do_write(1'b1, 15'h0000, 8'h00);
    ics_ram = 1'b1;
    #1 chk("disabled_ocs", {31'h0, ocs_ram}, 32'h0);
    chk("disabled_rtcsel", {31'h0, rtc_sel}, 32'h1);
    chk("disabled_dout", {24'h0, rtc_dout}, 32'hff);
    ics_ram = 1'b0;
    do_write(1'b1, 15'h0000, 8'h0a);

    // Full rollover: 59/59/23/511 ticks to zero with day carry
    rtc_wr(4'hc, 8'h01);
    rtc_wr(4'hb, 8'hff);
    rtc_wr(4'ha, 8'd23);
    rtc_wr(4'h9, 8'd59);
    do_write(1'b1, 15'h6000, 8'h00);
    rtc_wr(4'h8, 8'd59);
    repeat (7) @(posedge clk);
    #1 do_write(1'b1, 15'h6000, 8'h01);
    chk_rtc("roll_s", 4'h8, 8'h00);
    chk_rtc("roll_m", 4'h9, 8'h00);
    chk_rtc("roll_h", 4'ha, 8'h00);
    chk_rtc("roll_dl", 4'hb, 8'h00);
    chk_rtc("roll_dh", 4'hc, 8'h80);

    // S=63 wraps without carrying into M
    rtc_wr(4'h9, 8'h05);
    do_write(1'b1, 15'h6000, 8'h00);
    rtc_wr(4'h8, 8'd63);
    repeat (7) @(posedge clk);
    #1 do_write(1'b1, 15'h6000, 8'h01);
    chk_rtc("s63_s", 4'h8, 8'h00);
    chk_rtc("s63_m", 4'h9, 8'h05);

    // H=31 wraps without carrying into D
    rtc_wr(4'ha, 8'd31);
    rtc_wr(4'h9, 8'd59);
    do_write(1'b1, 15'h6000, 8'h00);
    rtc_wr(4'h8, 8'd59);
    repeat (7) @(posedge clk);
    #1 do_write(1'b1, 15'h6000, 8'h01);
    chk_rtc("h31_m", 4'h9, 8'h00);
    chk_rtc("h31_h", 4'ha, 8'h00);
    chk_rtc("h31_dl", 4'hb, 8'h00);
    chk_rtc("h31_dh", 4'hc, 8'h80);

    // Halt freezes counters; DH write with bit7=0 clears carry
    rtc_wr(4'hc, 8'h40);
    rtc_wr(4'h8, 8'd10);
    rtc_wr(4'h9, 8'd20);
    rtc_wr(4'ha, 8'd5);
    rtc_wr(4'hb, 8'd7);
    repeat (100) @(posedge clk);
    #1 do_write(1'b1, 15'h6000, 8'h00);
    do_write(1'b1, 15'h6000, 8'h01);
    chk_rtc("halt_s", 4'h8, 8'd10);
    chk_rtc("halt_m", 4'h9, 8'd20);
    chk_rtc("halt_h", 4'ha, 8'd5);
    chk_rtc("halt_dl", 4'hb, 8'd7);
    chk_rtc("halt_dh", 4'hc, 8'h40);

    // Broken latch sequence must not copy
    rtc_wr(4'h8, 8'd33);
    do_write(1'b1, 15'h6000, 8'h00);
    do_write(1'b1, 15'h6000, 8'h05);
    do_write(1'b1, 15'h6000, 8'h01);
    chk_rtc("latch_broken_s", 4'h8, 8'd10);
    do_write(1'b1, 15'h6000, 8'h00);
    do_write(1'b1, 15'h6000, 8'h01);
    chk_rtc("latch_ok_s", 4'h8, 8'd33);

    // Reset in the middle of a write
    ics_rom = 1'b1; iadr = 15'h2000; data = 8'h05; write = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midrst_ocs_rom", {31'h0, ocs_rom}, 32'h0);
    chk("midrst_dout", {24'h0, rtc_dout}, 32'hff);
    write = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 iadr = 15'h4000;
    #1 chk("midrst_no_commit", {10'h0, oadr}, 32'h004000);
    ics_rom = 1'b0; ics_ram = 1'b1;
    #1 chk("midrst_ena_cleared", {31'h0, rtc_sel}, 32'h1);
    chk("midrst_ocs_ram", {31'h0, ocs_ram}, 32'h0);
    ics_ram = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
